// File: rtl/memory_access_pkg.sv
// Shared types for the memory access sequencer.
// Holds the FSM state encoding and the transfer mode constants.
package memory_access_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic MODE_LOAD  = 1'b0;
  localparam logic MODE_STORE = 1'b1;

endpackage

// File: rtl/mas_byte_extend.sv
// Load result extender: keeps bytes below i_cnt, fills the rest
// with zero or, when i_sext is set, with bit 8*i_cnt-1.
// Ports: i_acc (assembled bytes), i_cnt (1..BYTES), i_sext, o_word.
module mas_byte_extend #(
  parameter int BYTES = 4
) (
  input  logic [8*BYTES-1:0] i_acc,
  input  logic [2:0]         i_cnt,
  input  logic               i_sext,
  output logic [8*BYTES-1:0] o_word
);

  logic       w_sign;
  logic [7:0] w_fill;

  always_comb begin
    w_sign = 1'b0;
    for (int b = 0; b < BYTES; b++) begin
      if (i_cnt == 3'(b + 1)) w_sign = i_acc[8*b+7];
    end
    w_fill = {8{w_sign & i_sext}};
    o_word = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (3'(b) < i_cnt) o_word[8*b +: 8] = i_acc[8*b +: 8];
      else               o_word[8*b +: 8] = w_fill;
    end
  end

endmodule

// File: rtl/memory_access_sequencer.sv
// Byte-serial load/store sequencer over an 8-bit async-read memory.
// Ports: Clock, Reset (async low), Start/Mode/Count/BaseAddr/WData
// request; MemOut in; Mem_Address/Mem_Data/Mem_WR/Mem_CS memory side;
// RData/Busy/Done status. Define MAS_SIGN_EXT_EN to add the SignExt
// input for sign-extended partial loads.
module memory_access_sequencer
  import memory_access_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int BYTES  = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Mode,
  input  logic [2:0]          Count,
  input  logic [ADDR_W-1:0]   BaseAddr,
  input  logic [8*BYTES-1:0]  WData,
  input  logic [7:0]          MemOut,
`ifdef MAS_SIGN_EXT_EN
  input  logic                SignExt,
`endif
  output logic [ADDR_W-1:0]   Mem_Address,
  output logic [7:0]          Mem_Data,
  output logic                Mem_WR,
  output logic                Mem_CS,
  output logic [8*BYTES-1:0]  RData,
  output logic                Busy,
  output logic                Done
);

  localparam int         DATA_W = 8 * BYTES;
  localparam logic [2:0] MAXC   = 3'(BYTES);

  state_t              r_state;
  state_t              w_next;
  logic                r_mode;
  logic [2:0]          r_cnt;
  logic [2:0]          r_idx;
  logic [ADDR_W-1:0]   r_base;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_rdata;
  logic [2:0]          w_cnt;
  logic                w_last;
  logic [DATA_W-1:0]   w_acc;
  logic [DATA_W-1:0]   w_ext;
  logic [7:0]          w_wbyte;
  logic                w_sext;

  assign w_cnt  = (Count == 3'd0 || Count > MAXC) ? MAXC : Count;
  assign w_last = (r_idx == r_cnt - 3'd1);

  // Merge the byte arriving this cycle so the final byte is
  // visible to the extender on the ACCESS->DONE edge.
  always_comb begin
    w_acc   = r_acc;
    w_wbyte = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (r_idx == 3'(b)) begin
        w_acc[8*b +: 8] = MemOut;
        w_wbyte         = r_wdata[8*b +: 8];
      end
    end
  end

`ifdef MAS_SIGN_EXT_EN
  logic r_sext;
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)                         r_sext <= 1'b0;
    else if (r_state == IDLE && Start)  r_sext <= SignExt;
  end
  assign w_sext = r_sext;
`else
  assign w_sext = 1'b0;
`endif

  mas_byte_extend #(.BYTES(BYTES)) u_ext (
    .i_acc  (w_acc),
    .i_cnt  (r_cnt),
    .i_sext (w_sext),
    .o_word (w_ext)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (Start) w_next = ACCESS;
      ACCESS:  if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_mode  <= MODE_LOAD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_base  <= '0;
      r_wdata <= '0;
      r_acc   <= '0;
      r_rdata <= '0;
    end else if (r_state == IDLE && Start) begin
      r_mode  <= Mode;
      r_cnt   <= w_cnt;
      r_idx   <= '0;
      r_base  <= BaseAddr;
      r_wdata <= WData;
      r_acc   <= '0;
    end else if (r_state == ACCESS) begin
      r_idx <= r_idx + 3'd1;
      if (r_mode == MODE_LOAD) begin
        r_acc <= w_acc;
        if (w_last) r_rdata <= w_ext;
      end
    end
  end

  assign Busy        = (r_state == ACCESS);
  assign Done        = (r_state == DONE);
  assign Mem_CS      = Busy;
  assign Mem_WR      = Busy & (r_mode == MODE_STORE);
  assign Mem_Address = Busy ? r_base + ADDR_W'(r_idx) : r_base;
  assign Mem_Data    = Mem_WR ? w_wbyte : 8'h00;
  assign RData       = r_rdata;

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Scoreboard bench for memory_access_sequencer with a byte memory model.
// Define MAS_SIGN_EXT_EN to also exercise sign-extended loads.
module tb_memory_access_sequencer;

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic        Mode;
  logic [2:0]  Count;
  logic [15:0] BaseAddr;
  logic [31:0] WData;
  logic [7:0]  MemOut;
  logic        SignExt;
  logic [15:0] Mem_Address;
  logic [7:0]  Mem_Data;
  logic        Mem_WR;
  logic        Mem_CS;
  logic [31:0] RData;
  logic        Busy;
  logic        Done;

  memory_access_sequencer dut (
    .Clock       (clk),
    .Reset       (rst_n),
    .Start       (Start),
    .Mode        (Mode),
    .Count       (Count),
    .BaseAddr    (BaseAddr),
    .WData       (WData),
    .MemOut      (MemOut),
`ifdef MAS_SIGN_EXT_EN
    .SignExt     (SignExt),
`endif
    .Mem_Address (Mem_Address),
    .Mem_Data    (Mem_Data),
    .Mem_WR      (Mem_WR),
    .Mem_CS      (Mem_CS),
    .RData       (RData),
    .Busy        (Busy),
    .Done        (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  assign MemOut = mem[Mem_Address];
  always @(posedge clk) if (Mem_CS && Mem_WR) mem[Mem_Address] <= Mem_Data;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  data;
  } acc_t;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    int          nbytes;
  } xfer_t;

  acc_t  acc_q[$];
  xfer_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int busy_run = 0;
  logic prev_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_xfer(input string name, input logic m,
                           input logic [15:0] b, input logic [31:0] wd,
                           input int n, input logic [31:0] rd);
    acc_t  a;
    xfer_t x;
    for (int i = 0; i < n; i++) begin
      a.addr = 16'(b + 16'(i));
      a.wr   = m;
      a.data = m ? wd[8*i +: 8] : 8'h00;
      acc_q.push_back(a);
    end
    x.name   = name;
    x.rdata  = rd;
    x.nbytes = n;
    exp_q.push_back(x);
  endtask

  task automatic wait_done(input string name, input int budget);
    int s;
    int i;
    s = n_done;
    i = 0;
    while (n_done == s && i < budget) begin
      @(posedge clk);
      i++;
    end
    #1;
    check({name, "_timeout"}, 64'(n_done == s), 64'd0);
  endtask

  task automatic issue(input string name, input logic m,
                       input logic [2:0] c, input logic [15:0] b,
                       input logic [31:0] wd, input logic se);
    Mode     = m;
    Count    = c;
    BaseAddr = b;
    WData    = wd;
    SignExt  = se;
    Start    = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    wait_done(name, 20);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run  = 0;
      prev_busy = 1'b0;
    end else begin
      if (Mem_CS) begin
        if (acc_q.size() == 0) begin
          check("unexpected_access", 64'(Mem_Address), 64'hFFFF_FFFF);
        end else begin
          acc_t a;
          a = acc_q.pop_front();
          check("mem_addr", 64'(Mem_Address), 64'(a.addr));
          check("mem_wr", 64'(Mem_WR), 64'(a.wr));
          if (a.wr) check("mem_data", 64'(Mem_Data), 64'(a.data));
        end
      end
      if (Busy) busy_run++;
      if (Done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(Done), 64'd0);
        end else begin
          xfer_t x;
          x = exp_q.pop_front();
          check({x.name, "_rdata"}, 64'(RData), 64'(x.rdata));
          check({x.name, "_busy_cycles"}, 64'(busy_run), 64'(x.nbytes));
          check({x.name, "_done_after_busy"}, 64'(prev_busy), 64'd1);
        end
        busy_run = 0;
      end
      prev_busy = Busy;
    end
  end

  initial begin
    rst_n    = 1'b0;
    Start    = 1'b0;
    Mode     = 1'b0;
    Count    = 3'd0;
    BaseAddr = 16'h0;
    WData    = 32'h0;
    SignExt  = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'h11;
    mem[16'h0011] = 8'h22;
    mem[16'h0012] = 8'h33;
    mem[16'h0013] = 8'h44;
    mem[16'h0102] = 8'h55;
    mem[16'h0300] = 8'h80;
    mem[16'hFFFF] = 8'hA1;
    mem[16'h0000] = 8'hB2;
    mem[16'h0001] = 8'hC3;
    #1;
    check("rst_addr", 64'(Mem_Address), 64'd0);
    check("rst_data", 64'(Mem_Data), 64'd0);
    check("rst_wr", 64'(Mem_WR), 64'd0);
    check("rst_cs", 64'(Mem_CS), 64'd0);
    check("rst_rdata", 64'(RData), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    push_xfer("load4", 1'b0, 16'h0010, 32'h0, 4, 32'h44332211);
    issue("load4", 1'b0, 3'd4, 16'h0010, 32'h0, 1'b0);

    push_xfer("store2", 1'b1, 16'h0100, 32'hDEADBEEF, 2, 32'h44332211);
    issue("store2", 1'b1, 3'd2, 16'h0100, 32'hDEADBEEF, 1'b0);
    check("store2_mem100", 64'(mem[16'h0100]), 64'hEF);
    check("store2_mem101", 64'(mem[16'h0101]), 64'hBE);
    check("store2_mem102", 64'(mem[16'h0102]), 64'h55);
    check("idle_addr_is_base", 64'(Mem_Address), 64'h0100);
    check("idle_cs", 64'(Mem_CS), 64'd0);

    push_xfer("load1", 1'b0, 16'h0300, 32'h0, 1, 32'h00000080);
    issue("load1", 1'b0, 3'd1, 16'h0300, 32'h0, 1'b0);

`ifdef MAS_SIGN_EXT_EN
    push_xfer("load1_sext", 1'b0, 16'h0300, 32'h0, 1, 32'hFFFFFF80);
    issue("load1_sext", 1'b0, 3'd1, 16'h0300, 32'h0, 1'b1);
`endif

    push_xfer("wrap3", 1'b0, 16'hFFFF, 32'h0, 3, 32'h00C3B2A1);
    issue("wrap3", 1'b0, 3'd3, 16'hFFFF, 32'h0, 1'b0);

    push_xfer("store_cnt5", 1'b1, 16'h0400, 32'h01020304, 4, 32'h00C3B2A1);
    issue("store_cnt5", 1'b1, 3'd5, 16'h0400, 32'h01020304, 1'b0);
    check("store_cnt5_mem400", 64'(mem[16'h0400]), 64'h04);
    check("store_cnt5_mem403", 64'(mem[16'h0403]), 64'h01);

    push_xfer("hold_a", 1'b0, 16'h0010, 32'h0, 4, 32'h44332211);
    push_xfer("hold_b", 1'b0, 16'h0010, 32'h0, 4, 32'h44332211);
    Mode     = 1'b0;
    Count    = 3'd0;
    BaseAddr = 16'h0010;
    Start    = 1'b1;
    wait_done("hold_a", 20);
    wait_done("hold_b", 20);
    Start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold_no_third", 64'(Busy), 64'd0);

    begin
      acc_t a;
      a.addr = 16'h0010;
      a.wr   = 1'b0;
      a.data = 8'h00;
      acc_q.push_back(a);
    end
    Mode     = 1'b0;
    Count    = 3'd4;
    BaseAddr = 16'h0010;
    Start    = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_cs", 64'(Mem_CS), 64'd0);
    check("abort_addr", 64'(Mem_Address), 64'd0);
    check("abort_wr", 64'(Mem_WR), 64'd0);
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_done", 64'(Done), 64'd0);
    check("abort_rdata", 64'(RData), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_busy", 64'(Busy), 64'd0);
    check("post_rst_rdata", 64'(RData), 64'd0);

    push_xfer("post_rst_load2", 1'b0, 16'h0010, 32'h0, 2, 32'h00002211);
    issue("post_rst_load2", 1'b0, 3'd2, 16'h0010, 32'h0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("acc_q_drained", 64'(acc_q.size()), 64'd0);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
